// File: rtl/key_auth_pkg.sv
// Shared state encodings and default authentication constants for the
// key transponder authenticator.
package key_auth_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_REQ   = 3'd1;
  localparam state_t ST_RECV  = 3'd2;
  localparam state_t ST_CHECK = 3'd3;
  localparam state_t ST_GO    = 3'd4;
  localparam state_t ST_LOCK  = 3'd5;

  localparam int DEF_N_KEYS   = 4;
  localparam int DEF_CODE_W   = 4;
  localparam int DEF_MAX_FAIL = 3;
  localparam int DEF_LOCK_CYC = 16;

  localparam logic [DEF_CODE_W-1:0] DEF_CODE = 4'b1011;

endpackage

// File: rtl/key_auth_arbiter_rr_pick.sv
// Combinational round-robin picker: first present key at or after rr_ptr,
// searching cyclically.
module rr_pick #(
  parameter int N_KEYS = 4,
  parameter int GW     = $clog2(N_KEYS)
) (
  input  logic [N_KEYS-1:0] key_present,
  input  logic [GW-1:0]     rr_ptr,
  output logic [GW-1:0]     grant,
  output logic              valid
);

  logic [GW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest present key wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = N_KEYS-1; i >= 0; i--) begin
      idx = GW'((int'(rr_ptr) + i) % N_KEYS);
      if (key_present[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_auth_arbiter.sv
// Shared serial-code authenticator: arbitrates key transponders round-robin,
// checks each received code and locks out after repeated mismatches.
module key_auth_arbiter
  import key_auth_pkg::*;
#(
  parameter int                N_KEYS   = DEF_N_KEYS,
  parameter int                CODE_W   = DEF_CODE_W,
  parameter logic [CODE_W-1:0] CODE     = DEF_CODE,
  parameter int                MAX_FAIL = DEF_MAX_FAIL,
  parameter int                LOCK_CYC = DEF_LOCK_CYC,
  parameter int                GW       = $clog2(N_KEYS),
  parameter int                FW       = $clog2(MAX_FAIL+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              comeca,
  input  logic [N_KEYS-1:0] key_present,
  input  logic [N_KEYS-1:0] key_code,
  output logic [N_KEYS-1:0] key_req,
  output logic [GW-1:0]     grant,
  output logic              start,
  output logic              busy,
  output logic              locked,
  output logic [FW-1:0]     fail_cnt
);

  localparam int BW = $clog2(CODE_W+1);
  localparam int LW = $clog2(LOCK_CYC+1);

  state_t            state;
  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     grant_r;
  logic [GW-1:0]     next_ptr;
  logic [CODE_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic [FW-1:0]     fail_cnt_r;
  logic [LW-1:0]     lock_cnt;
  logic [GW-1:0]     pick_grant;
  logic              pick_valid;

  rr_pick #(
    .N_KEYS(N_KEYS),
    .GW    (GW)
  ) u_rr_pick (
    .key_present(key_present),
    .rr_ptr     (rr_ptr),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  assign next_ptr = (grant_r == GW'(N_KEYS-1)) ? '0 : grant_r + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      grant_r    <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      fail_cnt_r <= '0;
      lock_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (comeca && pick_valid) begin
            grant_r <= pick_grant;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          bit_cnt <= '0;
          state   <= ST_RECV;
        end
        ST_RECV: begin
          shreg <= {shreg[CODE_W-2:0], key_code[grant_r]};
          if (bit_cnt == BW'(CODE_W-1)) state <= ST_CHECK;
          else bit_cnt <= bit_cnt + 1'b1;
        end
        ST_CHECK: begin
          rr_ptr <= next_ptr;
          if (shreg == CODE) begin
            fail_cnt_r <= '0;
            state      <= ST_GO;
          end else begin
            // The final mismatch lands fail_cnt exactly on MAX_FAIL and holds there.
            fail_cnt_r <= fail_cnt_r + 1'b1;
            if (fail_cnt_r == FW'(MAX_FAIL-1)) begin
              lock_cnt <= LW'(LOCK_CYC-1);
              state    <= ST_LOCK;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_GO: state <= ST_IDLE;
        ST_LOCK: begin
          if (lock_cnt == '0) begin
            fail_cnt_r <= '0;
            state      <= ST_IDLE;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign key_req  = (state == ST_REQ) ? (N_KEYS'(1) << grant_r) : '0;
  assign grant    = (state == ST_IDLE) ? '0 : grant_r;
  assign start    = (state == ST_GO);
  assign busy     = (state != ST_IDLE);
  assign locked   = (state == ST_LOCK);
  assign fail_cnt = fail_cnt_r;

endmodule
